ahb_cmd_manager: RTL and testbench

Synthesizable AHB-Lite manager for the testbench: turns a simple valid/ready command stream into single (HBURST=SINGLE) AHB transfers, pipelines one address phase over the current data phase, and reports each completion on a response port. It is the initiator end of the subordinate-side AHB error injection path. It must honour the two-cycle ERROR response by cancelling any pending address phase. It also counts errors and flags hung subordinates.

---
 rtl/ahb_cmd_pkg.sv | 33 +++
 rtl/ahb_cmd_manager_if.sv | 52 +++++
 rtl/ahb_wait_timer.sv | 47 ++++
 rtl/ahb_cmd_manager.sv | 166 ++++++++++++++++
 tb/tb_ahb_cmd_manager.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_cmd_pkg
// Description : Shared AHB encodings, FSM states and command record.
// Revision    : 1.0
// ============================================================================
package ahb_cmd_pkg;

    localparam int CMD_ADDR_WIDTH = 32;
    localparam int CMD_DATA_WIDTH = 64;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        ERR2 = 1'b1
    } state_e;

    typedef struct packed {
        logic                      write;
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic [2:0]                size;
        logic [CMD_DATA_WIDTH-1:0] wdata;
    } cmd_t;

endpackage : ahb_cmd_pkg
`default_nettype wire

// File: rtl/ahb_cmd_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_cmd_manager_if
// Description : Command, response and AHB-Lite manager signal bundle.
// Revision    : 1.0
// ============================================================================
interface ahb_cmd_manager_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [2:0]            cmd_size;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_error;
    logic                  rsp_abort;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_error, rsp_abort, rsp_rdata,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_error, rsp_abort, rsp_rdata,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );

endinterface : ahb_cmd_manager_if
`default_nettype wire

// File: rtl/ahb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : ahb_wait_timer
// Description : Counts consecutive data-phase wait cycles; sticky hang flag.
// Revision    : 1.0
// ============================================================================
module ahb_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_wait,
    output logic      o_hang
);

    if (TIMEOUT > 0) begin : g_timer
        localparam int                 c_cnt_w = $clog2(TIMEOUT + 1);
        localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);
        localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT - 1);

        logic [c_cnt_w-1:0] r_count;
        logic               r_hang;

        // Count saturates at the limit so a long stall cannot wrap around.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_count <= '0;
                r_hang  <= 1'b0;
            end else if (i_wait) begin
                if (r_count != c_limit) begin
                    r_count <= r_count + c_cnt_w'(1);
                end
                if (r_count == c_last) begin
                    r_hang <= 1'b1;
                end
            end else begin
                r_count <= '0;
            end
        end

        assign o_hang = r_hang;
    end else begin : g_no_timer
        assign o_hang = 1'b0;
    end

endmodule : ahb_wait_timer
`default_nettype wire

// File: rtl/ahb_cmd_manager.sv
`default_nettype none
// ============================================================================
// Module      : ahb_cmd_manager
// Description : Command stream to single AHB-Lite transfers with one-deep
//               address pipelining, ERROR handling, error count, hang flag.
// Revision    : 1.0
// ============================================================================
module ahb_cmd_manager
    import ahb_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_WIDTH,
    parameter int DATA_WIDTH = CMD_DATA_WIDTH,
    parameter int TIMEOUT    = 256
) (
    input  wire logic          HCLK,
    input  wire logic          HRESET,
    ahb_cmd_manager_if.master  bus,
    output logic [15:0]        err_count,
    output logic               hang
);

    localparam logic [2:0] c_max_size = 3'($clog2(DATA_WIDTH / 8));

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_a_vld;
    cmd_t                  r_a_cmd;
    logic                  r_d_vld;
    logic                  r_d_write;
    logic [DATA_WIDTH-1:0] r_d_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_error;
    logic                  r_rsp_abort;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [15:0]           r_err_count;

    logic w_cmd_ready;
    logic w_cmd_load;
    logic w_a_adv;
    logic w_d_done;
    logic w_err_enter;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ERR2 is the second cycle of an ERROR response; stay until HREADY rises.
    always_comb begin
        w_state_nxt = r_state;
        w_a_adv     = 1'b0;
        w_err_enter = 1'b0;
        w_cmd_ready = 1'b0;
        w_d_done    = r_d_vld && bus.HREADY;
        case (r_state)
            RUN: begin
                w_a_adv     = r_a_vld && bus.HREADY;
                w_err_enter = r_d_vld && bus.HRESP && !bus.HREADY;
                w_cmd_ready = !r_a_vld || bus.HREADY;
                if (w_err_enter) begin
                    w_state_nxt = ERR2;
                end
            end
            ERR2: begin
                if (bus.HREADY || !bus.HRESP) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_cmd_load = bus.cmd_valid && w_cmd_ready;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_a_vld     <= 1'b0;
            r_a_cmd     <= '0;
            r_d_vld     <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_wdata   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_abort <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_abort <= 1'b0;
            r_rsp_rdata <= '0;

            // A pending address phase behind an errored transfer is cancelled
            // on entry to ERR2, so its abort pulse precedes the completion.
            if (w_err_enter && r_a_vld) begin
                r_a_vld     <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_error <= 1'b1;
                r_rsp_abort <= 1'b1;
            end else if (w_cmd_load) begin
                r_a_vld <= 1'b1;
                r_a_cmd <= '{write: bus.cmd_write, addr: bus.cmd_addr,
                             size: bus.cmd_size, wdata: bus.cmd_wdata};
            end else if (w_a_adv) begin
                r_a_vld <= 1'b0;
            end

            if (w_a_adv) begin
                r_d_vld   <= 1'b1;
                r_d_write <= r_a_cmd.write;
                r_d_wdata <= r_a_cmd.wdata;
            end else if (w_d_done) begin
                r_d_vld <= 1'b0;
            end

            if (w_d_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= bus.HRESP;
                r_rsp_rdata <= r_d_write ? '0 : bus.HRDATA;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_err_count <= '0;
        end else if (r_rsp_valid && r_rsp_error && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    ahb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (HCLK),
        .rst    (HRESET),
        .i_wait (r_d_vld && !bus.HREADY),
        .o_hang (hang)
    );

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_error = r_rsp_error;
    assign bus.rsp_abort = r_rsp_abort;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.HTRANS    = (r_a_vld && (r_state != ERR2)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = r_a_cmd.addr;
    assign bus.HWRITE    = r_a_cmd.write;
    assign bus.HSIZE     = r_a_cmd.size;
    assign bus.HWDATA    = r_d_wdata;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DATA_PRIV;
    assign bus.HMASTLOCK = 1'b0;
    assign err_count     = r_err_count;

    a_err2_hresp : assert property (@(posedge HCLK) disable iff (HRESET)
        (r_state == ERR2) |-> bus.HRESP);
    a_cmd_size : assert property (@(posedge HCLK) disable iff (HRESET)
        w_cmd_load |-> (bus.cmd_size <= c_max_size));
    a_single_only : assert property (@(posedge HCLK) disable iff (HRESET)
        (bus.HTRANS != HTRANS_BUSY) && (bus.HTRANS != HTRANS_SEQ));

endmodule : ahb_cmd_manager
`default_nettype wire

// File: tb/tb_ahb_cmd_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_cmd_manager
// Description : Directed scoreboard bench for ahb_cmd_manager.
// Revision    : 1.0
// ============================================================================
module tb_ahb_cmd_manager;

    typedef struct {
        logic        err;
        logic        abort;
        logic [63:0] rdata;
    } exp_t;

    logic        HCLK;
    logic        HRESET;
    logic [15:0] err_count;
    logic        hang;
    int          checks;
    int          failures;
    exp_t        exp_q[$];

    ahb_cmd_manager_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

    ahb_cmd_manager #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .TIMEOUT    (8)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus.master),
        .err_count (err_count),
        .hang      (hang)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic err, input logic abort, input logic [63:0] rdata);
        exp_t e;
        e.err   = err;
        e.abort = abort;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [63:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_size  = 3'd3;
        bus.cmd_wdata = wdata;
    endtask

    // Scoreboard monitor: every response pulse is matched against the queue.
    always @(negedge HCLK) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 err=%b abort=%b expected no response",
                         bus.rsp_error, bus.rsp_abort);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_error", 64'(bus.rsp_error), 64'(e.err));
                chk("rsp_abort", 64'(bus.rsp_abort), 64'(e.abort));
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            end
        end
    end

    logic [31:0] wa[4];
    logic [63:0] wd[4];

    initial begin
        checks        = 0;
        failures      = 0;
        HRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_size  = '0;
        bus.cmd_wdata = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = '0;
        for (int k = 0; k < 4; k++) begin
            wa[k] = 32'(k * 8);
            wd[k] = 64'hA5A5_0000_0000_0000 | 64'(k + 1);
        end

        // Reset state
        repeat (3) @(negedge HCLK);
        #1;
        chk("rst_htrans",   64'(bus.HTRANS), 64'd0);
        chk("rst_haddr",    64'(bus.HADDR),  64'd0);
        chk("rst_hwrite",   64'(bus.HWRITE), 64'd0);
        chk("rst_hsize",    64'(bus.HSIZE),  64'd0);
        chk("rst_hwdata",   bus.HWDATA,      64'd0);
        chk("rst_rsp",      64'(bus.rsp_valid), 64'd0);
        chk("rst_errcnt",   64'(err_count),  64'd0);
        chk("rst_hang",     64'(hang),       64'd0);
        chk("const_hburst", 64'(bus.HBURST), 64'd0);
        chk("const_hprot",  64'(bus.HPROT),  64'd3);
        chk("const_hlock",  64'(bus.HMASTLOCK), 64'd0);
        HRESET = 1'b0;

        // Zero-wait read
        @(negedge HCLK);
        issue(1'b0, 32'h1000, '0);
        bus.HRDATA = 64'hDEAD_BEEF;
        push(1'b0, 1'b0, 64'hDEAD_BEEF);
        #1 chk("t1_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        #1;
        chk("t1_nonseq", 64'(bus.HTRANS), 64'd2);
        chk("t1_haddr",  64'(bus.HADDR),  64'h1000);
        chk("t1_hwrite", 64'(bus.HWRITE), 64'd0);
        @(negedge HCLK);
        #1;
        chk("t1_idle",      64'(bus.HTRANS),    64'd0);
        chk("t1_rsp_early", 64'(bus.rsp_valid), 64'd0);
        @(negedge HCLK);
        #1 chk("t1_rsp_lat", 64'(bus.rsp_valid), 64'd1);
        @(negedge HCLK);

        // Four back-to-back writes
        bus.HRDATA = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int j = 0; j < 6; j++) begin
            @(negedge HCLK);
            if (j < 4) begin
                issue(1'b1, wa[j], wd[j]);
                push(1'b0, 1'b0, 64'd0);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            #1;
            if (j < 4) chk("t2_ready", 64'(bus.cmd_ready), 64'd1);
            if (j >= 1 && j <= 4) begin
                chk("t2_nonseq", 64'(bus.HTRANS), 64'd2);
                chk("t2_haddr",  64'(bus.HADDR),  64'(wa[j-1]));
            end
            if (j >= 2) chk("t2_hwdata", bus.HWDATA, wd[j-2]);
        end
        repeat (2) @(negedge HCLK);

        // Two-cycle ERROR with a queued read
        @(negedge HCLK);
        issue(1'b1, 32'h2000, 64'h1234);
        @(negedge HCLK);
        issue(1'b0, 32'h2008, '0);
        push(1'b1, 1'b1, 64'd0);
        push(1'b1, 1'b0, 64'd0);
        #1 chk("t3_haddr_w", 64'(bus.HADDR), 64'h2000);
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        bus.HREADY    = 1'b0;
        bus.HRESP     = 1'b1;
        #1;
        chk("t3_haddr_r", 64'(bus.HADDR),     64'h2008);
        chk("t3_ready0",  64'(bus.cmd_ready), 64'd0);
        @(negedge HCLK);
        bus.HREADY = 1'b1;
        #1;
        chk("t3_idle",    64'(bus.HTRANS),    64'd0);
        chk("t3_abort",   64'(bus.rsp_abort), 64'd1);
        chk("t3_ready_e", 64'(bus.cmd_ready), 64'd0);
        @(negedge HCLK);
        bus.HRESP = 1'b0;
        #1 chk("t3_wr_rsp", 64'(bus.rsp_valid), 64'd1);
        @(negedge HCLK);
        #1 chk("t3_errcnt", 64'(err_count), 64'd2);

        // Three wait states
        @(negedge HCLK);
        issue(1'b1, 32'h3000, 64'hCAFE_F00D);
        push(1'b0, 1'b0, 64'd0);
        @(negedge HCLK);
        issue(1'b0, 32'h3008, '0);
        bus.HRDATA = 64'h0BAD_0BAD;
        push(1'b0, 1'b0, 64'h0BAD_0BAD);
        for (int w = 0; w < 3; w++) begin
            @(negedge HCLK);
            bus.cmd_valid = 1'b0;
            bus.HREADY    = 1'b0;
            #1;
            chk("t4_haddr",  64'(bus.HADDR),     64'h3008);
            chk("t4_hwdata", bus.HWDATA,         64'hCAFE_F00D);
            chk("t4_ready0", 64'(bus.cmd_ready), 64'd0);
            chk("t4_rsp0",   64'(bus.rsp_valid), 64'd0);
        end
        @(negedge HCLK);
        bus.HREADY = 1'b1;
        #1 chk("t4_hang0", 64'(hang), 64'd0);
        repeat (3) @(negedge HCLK);

        // Hang after eight wait cycles
        issue(1'b0, 32'h4000, '0);
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        for (int h = 0; h < 8; h++) begin
            @(negedge HCLK);
            bus.HREADY = 1'b0;
            #1 chk("t5_hang_pre", 64'(hang), 64'd0);
        end
        @(negedge HCLK);
        #1 chk("t5_hang_set", 64'(hang), 64'd1);
        bus.HREADY = 1'b1;
        bus.HRDATA = 64'h4444;
        push(1'b0, 1'b0, 64'h4444);
        @(negedge HCLK);
        @(negedge HCLK);
        #1 chk("t5_hang_sticky", 64'(hang), 64'd1);

        // Reset during a data phase
        @(negedge HCLK);
        issue(1'b0, 32'h5000, '0);
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        @(negedge HCLK);
        bus.HREADY = 1'b0;
        HRESET     = 1'b1;
        @(negedge HCLK);
        HRESET     = 1'b0;
        bus.HREADY = 1'b1;
        #1;
        chk("t6_idle",   64'(bus.HTRANS),    64'd0);
        chk("t6_rsp0",   64'(bus.rsp_valid), 64'd0);
        chk("t6_errcnt", 64'(err_count),     64'd0);
        chk("t6_hang",   64'(hang),          64'd0);
        repeat (2) begin
            @(negedge HCLK);
            #1 chk("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end

        repeat (2) @(negedge HCLK);
        chk("rsp_pending", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ahb_cmd_manager
`default_nettype wire
